// File: rtl/serial_compare_ctrl.sv
// Serial MSB-first unsigned compare through one external 1-bit slice; SERIAL_CMP_EARLY_EXIT_EN ends on first differing bit.
// Latency: accept on edge k, out_valid after edge k+WIDTH (or k+first-diff-position with early exit).
// Backpressure: one compare in flight; in_ready low from accept until the result is taken with out_ready.
module serial_compare_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [WIDTH-1:0]           in_b,
    output logic                       cmp_a,
    output logic                       cmp_b,
    input  logic                       cmp_lt,
    input  logic                       cmp_eq,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_lt,
    output logic                       out_eq,
    output logic                       out_gt,
    output logic [$clog2(WIDTH+1)-1:0] out_cycles
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [CW-1:0]    cnt;
    logic             decided;
    logic             dec_lt;

    logic differ;
    logic last;
    logic lt_now;
    logic gt_now;
    logic eq_now;

    // cmp_a/cmp_b are held in registers, so the slice outputs are valid within the same cycle
    assign differ = ~cmp_eq & ~decided;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    assign last   = (cnt == CW'(1)) | differ;
`else
    assign last   = (cnt == CW'(1));
`endif
    assign lt_now = decided ? dec_lt  : (differ & cmp_lt);
    assign gt_now = decided ? ~dec_lt : (differ & ~cmp_lt);
    assign eq_now = ~decided & ~differ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_lt     <= 1'b0;
            out_eq     <= 1'b0;
            out_gt     <= 1'b0;
            out_cycles <= '0;
            cmp_a      <= 1'b0;
            cmp_b      <= 1'b0;
            sh_a       <= '0;
            sh_b       <= '0;
            cnt        <= '0;
            decided    <= 1'b0;
            dec_lt     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // MSB goes straight to the slice; the rest waits in the shift regs
                        cmp_a      <= in_a[WIDTH-1];
                        cmp_b      <= in_b[WIDTH-1];
                        sh_a       <= in_a << 1;
                        sh_b       <= in_b << 1;
                        cnt        <= CW'(WIDTH);
                        decided    <= 1'b0;
                        dec_lt     <= 1'b0;
                        out_lt     <= 1'b0;
                        out_eq     <= 1'b0;
                        out_gt     <= 1'b0;
                        out_cycles <= '0;
                        in_ready   <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    sh_a       <= sh_a << 1;
                    sh_b       <= sh_b << 1;
                    cnt        <= cnt - CW'(1);
                    out_cycles <= out_cycles + CW'(1);
                    if (differ) begin
                        decided <= 1'b1;
                        dec_lt  <= cmp_lt;
                    end
                    if (last) begin
                        cmp_a     <= 1'b0;
                        cmp_b     <= 1'b0;
                        cnt       <= '0;
                        out_lt    <= lt_now;
                        out_eq    <= eq_now;
                        out_gt    <= gt_now;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cmp_a <= sh_a[WIDTH-1];
                        cmp_b <= sh_b[WIDTH-1];
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    cmp_a     <= 1'b0;
                    cmp_b     <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Directed bench for serial_compare_ctrl with a behavioural 1-bit slice and a result scoreboard.
module tb_serial_compare_ctrl;
    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          cmp_a;
    logic          cmp_b;
    logic          cmp_lt;
    logic          cmp_eq;
    logic          out_valid;
    logic          out_ready;
    logic          out_lt;
    logic          out_eq;
    logic          out_gt;
    logic [CW-1:0] out_cycles;

    typedef struct packed {
        logic          lt;
        logic          eq;
        logic          gt;
        logic [CW-1:0] ncyc;
    } res_t;

    res_t sb[$];
    int   passed  = 0;
    int   failed  = 0;
    int   total   = 0;
    int   cyc     = 0;
    int   acc_cyc = 0;

    serial_compare_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .cmp_a      (cmp_a),
        .cmp_b      (cmp_b),
        .cmp_lt     (cmp_lt),
        .cmp_eq     (cmp_eq),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_lt     (out_lt),
        .out_eq     (out_eq),
        .out_gt     (out_gt),
        .out_cycles (out_cycles)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign cmp_lt = ~cmp_a & cmp_b;
    assign cmp_eq = ~(cmp_a ^ cmp_b);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        res_t r;
        r.lt   = (a < b);
        r.eq   = (a == b);
        r.gt   = (a > b);
        r.ncyc = CW'(W);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        begin
            bit found = 1'b0;
            for (int i = W - 1; i >= 0; i--) begin
                if (!found && a[i] != b[i]) begin
                    found  = 1'b1;
                    r.ncyc = CW'(W - i);
                end
            end
        end
`endif
        return r;
    endfunction

    // Called at a negedge; returns at the negedge of the first RUN cycle.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit push, input bit hold);
        int n = 0;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        if (push) sb.push_back(model(a, b));
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 acc_cyc = cyc;
        if (!hold) in_valid = 1'b0;
        @(negedge clk);
        check("in_ready_in_run", in_ready, 32'd0);
        check("cmp_a_msb", cmp_a, a[W-1]);
        check("cmp_b_msb", cmp_b, b[W-1]);
    endtask

    task automatic get(input int stall);
        res_t e;
        int   n = 0;
        out_ready = (stall == 0);
        while (out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            check("result_timeout", 32'd0, 32'd1);
            return;
        end
        if (sb.size() == 0) begin
            check("unexpected_result", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check("latency", cyc - acc_cyc, e.ncyc);
        check("lt_eq_gt", {out_lt, out_eq, out_gt}, {e.lt, e.eq, e.gt});
        check("out_cycles", out_cycles, e.ncyc);
        check("cmp_idle_done", {cmp_a, cmp_b}, 2'b00);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("hold_valid", out_valid, 32'd1);
            check("hold_result", {out_lt, out_eq, out_gt, out_cycles}, e);
            check("hold_in_ready", in_ready, 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("post_hs_valid", out_valid, 32'd0);
        check("post_hs_in_ready", in_ready, 32'd1);
    endtask

    initial begin
        bit seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_a      = '0;
        in_b      = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 32'd1);
        check("rst_out_valid", out_valid, 32'd0);
        check("rst_result", {out_lt, out_eq, out_gt, out_cycles}, 32'd0);
        check("rst_cmp", {cmp_a, cmp_b}, 2'b00);
        rst = 1'b0;
        @(negedge clk);

        // equal operands, different-at-MSB, different-at-LSB
        send(8'h5A, 8'h5A, 1'b1, 1'b0);
        get(0);
        send(8'h80, 8'h7F, 1'b1, 1'b0);
        get(0);
        send(8'h12, 8'h13, 1'b1, 1'b0);
        get(0);

        // consumer stalls for 5 cycles
        send(8'hC3, 8'h3C, 1'b1, 1'b0);
        get(5);

        // reset in the 3rd RUN cycle discards the compare
        send(8'hFF, 8'h00, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 check("pre_rst_in_ready", in_ready, 32'd0);
        #1 rst = 1'b1;
        #1;
        check("arst_in_ready", in_ready, 32'd1);
        check("arst_out_valid", out_valid, 32'd0);
        check("arst_result", {out_lt, out_eq, out_gt, out_cycles}, 32'd0);
        check("arst_cmp", {cmp_a, cmp_b}, 2'b00);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        check("no_valid_after_rst", seen, 32'd0);
        send(8'h01, 8'h02, 1'b1, 1'b0);
        get(0);

        // back-to-back with in_valid held through DONE
        send(8'hA0, 8'hA1, 1'b1, 1'b1);
        in_a = 8'h33;
        in_b = 8'h33;
        sb.push_back(model(8'h33, 8'h33));
        get(0);
        @(posedge clk);
        #1 acc_cyc = cyc;
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b_accept", in_ready, 32'd0);
        get(0);

        for (int i = 0; i < 6; i++) begin
            send(W'($urandom), W'($urandom), 1'b1, 1'b0);
            get(0);
        end
        check("sb_empty", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
